// File: rtl/bistable_bank.sv
// Bank of pulse-gated bistables: per-bit set/clear/complement driven by gated
// rising edges on shared pulse lines, with level direct clear/preset overrides.
module bistable_bank #(
  parameter int unsigned      WIDTH       = 12,
  parameter int unsigned      CHANNELS    = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         pulse_clr,
  input  logic [CHANNELS*WIDTH-1:0]   gate_clr,
  input  logic [CHANNELS-1:0]         pulse_set,
  input  logic [CHANNELS*WIDTH-1:0]   gate_set,
  input  logic                        pulse_comp,
  input  logic [WIDTH-1:0]            gate_comp,
  input  logic                        dc_clear,
  input  logic                        dc_preset,
  output logic [WIDTH-1:0]            b,
  output logic [WIDTH-1:0]            p,
  output logic [WIDTH-1:0]            changed
);

  logic [CHANNELS-1:0] pulse_clr_q;
  logic [CHANNELS-1:0] pulse_set_q;
  logic                pulse_comp_q;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [WIDTH-1:0]    p_q;
  logic [WIDTH-1:0]    changed_q, changed_d;

  logic [CHANNELS-1:0] clr_edge;
  logic [CHANNELS-1:0] set_edge;
  logic                comp_edge;
  logic [WIDTH-1:0]    set_req;
  logic [WIDTH-1:0]    clr_req;
  logic [WIDTH-1:0]    toggle;

  // Edge detect, request merge across channels, and per-bit resolution.
  always_comb begin
    clr_edge  = pulse_clr & ~pulse_clr_q;
    set_edge  = pulse_set & ~pulse_set_q;
    comp_edge = pulse_comp & ~pulse_comp_q;
    set_req   = '0;
    clr_req   = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      set_req = set_req | ({WIDTH{set_edge[c]}} & gate_set[c*WIDTH +: WIDTH]);
      clr_req = clr_req | ({WIDTH{clr_edge[c]}} & gate_clr[c*WIDTH +: WIDTH]);
    end
    // Simultaneous set and clear on a bit behaves like a complement.
    toggle = ({WIDTH{comp_edge}} & gate_comp) | (set_req & clr_req);
    b_d    = (toggle & ~b_q) | (~toggle & set_req) | (~toggle & ~set_req & ~clr_req & b_q);
    if (dc_clear) begin
      b_d = '0;
    end else if (dc_preset) begin
      b_d = '1;
    end
    changed_d = b_d ^ b_q;
  end

  // Previous-value registers track the lines even in reset so a held line gives no edge.
  always_ff @(posedge clk) begin
    pulse_clr_q  <= pulse_clr;
    pulse_set_q  <= pulse_set;
    pulse_comp_q <= pulse_comp;
    if (reset) begin
      b_q       <= RESET_VALUE;
      p_q       <= ~RESET_VALUE;
      changed_q <= '0;
    end else begin
      b_q       <= b_d;
      p_q       <= ~b_d;
      changed_q <= changed_d;
    end
  end

  assign b       = b_q;
  assign p       = p_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_bistable_bank.sv
// Directed self-checking bench for bistable_bank (WIDTH=4, CHANNELS=2).
module tb_bistable_bank;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned CHANNELS = 2;

  logic                      clk;
  logic                      reset;
  logic [CHANNELS-1:0]       pulse_clr;
  logic [CHANNELS*WIDTH-1:0] gate_clr;
  logic [CHANNELS-1:0]       pulse_set;
  logic [CHANNELS*WIDTH-1:0] gate_set;
  logic                      pulse_comp;
  logic [WIDTH-1:0]          gate_comp;
  logic                      dc_clear;
  logic                      dc_preset;
  logic [WIDTH-1:0]          b;
  logic [WIDTH-1:0]          p;
  logic [WIDTH-1:0]          changed;

  int n_assert = 0;
  int n_fail   = 0;

  bistable_bank #(
    .WIDTH      (WIDTH),
    .CHANNELS   (CHANNELS),
    .RESET_VALUE(4'b1111)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pulse_clr (pulse_clr),
    .gate_clr  (gate_clr),
    .pulse_set (pulse_set),
    .gate_set  (gate_set),
    .pulse_comp(pulse_comp),
    .gate_comp (gate_comp),
    .dc_clear  (dc_clear),
    .dc_preset (dc_preset),
    .b         (b),
    .p         (p),
    .changed   (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [WIDTH-1:0] exp_b, input logic [WIDTH-1:0] exp_ch);
    chk({tag, ".b"}, b, exp_b);
    chk({tag, ".p"}, p, ~exp_b);
    chk({tag, ".changed"}, changed, exp_ch);
  endtask

  task automatic idle();
    pulse_clr  = '0;
    pulse_set  = '0;
    pulse_comp = 1'b0;
    gate_clr   = '0;
    gate_set   = '0;
    gate_comp  = '0;
    dc_clear   = 1'b0;
    dc_preset  = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    chk_all("reset", 4'b1111, 4'b0000);

    // Ungated pulse edge does nothing.
    reset = 1'b0;
    pulse_clr[0] = 1'b1;
    step();
    chk_all("ungated_clr", 4'b1111, 4'b0000);
    idle();
    step();

    // Held pulse acts only on its first edge.
    gate_clr[3:0] = 4'b0101;
    pulse_clr[0]  = 1'b1;
    step();
    chk_all("clr_edge", 4'b1010, 4'b0101);
    step();
    chk_all("clr_held1", 4'b1010, 4'b0000);
    step();
    chk_all("clr_held2", 4'b1010, 4'b0000);
    idle();
    step();
    chk_all("clr_fall", 4'b1010, 4'b0000);

    // Set on ch1 plus clear on ch0: bit1 toggles, bit0 sets.
    gate_set[7:4] = 4'b0011;
    gate_clr[3:0] = 4'b0010;
    pulse_set[1]  = 1'b1;
    pulse_clr[0]  = 1'b1;
    step();
    chk_all("set_clr_mix", 4'b1001, 4'b0011);
    idle();
    step();

    // Set on a bit already 1 from both channels: no change.
    gate_set      = 8'b1000_1001;
    pulse_set     = 2'b11;
    step();
    chk_all("redundant_set", 4'b1001, 4'b0000);
    idle();
    step();

    // Complement wins over a gated set.
    gate_comp     = 4'b1111;
    pulse_comp    = 1'b1;
    gate_set[7:4] = 4'b0010;
    pulse_set[1]  = 1'b1;
    step();
    chk_all("comp_wins", 4'b0110, 4'b1111);
    idle();
    step();
    chk_all("comp_after", 4'b0110, 4'b0000);

    // dc_clear beats dc_preset; pulse edges during dc are discarded.
    dc_clear  = 1'b1;
    dc_preset = 1'b1;
    step();
    chk_all("dc_both1", 4'b0000, 4'b0110);
    gate_set[3:0] = 4'b1111;
    pulse_set[0]  = 1'b1;
    step();
    chk_all("dc_both2", 4'b0000, 4'b0000);
    dc_clear  = 1'b0;
    dc_preset = 1'b0;
    step();
    chk_all("dc_release", 4'b0000, 4'b0000);
    pulse_set[0] = 1'b0;
    step();
    chk_all("dc_no_replay", 4'b0000, 4'b0000);

    // dc_preset alone, then hold after release.
    idle();
    dc_preset = 1'b1;
    step();
    chk_all("dc_preset", 4'b1111, 4'b1111);
    dc_preset = 1'b0;
    step();
    chk_all("preset_hold", 4'b1111, 4'b0000);

    // Reset overrides a simultaneous gated clear edge; lines held through reset give no edge.
    gate_clr[7:4] = 4'b1111;
    gate_set[3:0] = 4'b1111;
    pulse_clr[1]  = 1'b1;
    pulse_set[0]  = 1'b1;
    reset = 1'b1;
    step();
    chk_all("reset_override", 4'b1111, 4'b0000);
    reset = 1'b0;
    step();
    chk_all("held_thru_reset", 4'b1111, 4'b0000);
    pulse_clr[1] = 1'b0;
    pulse_set[0] = 1'b0;
    step();
    chk_all("held_release", 4'b1111, 4'b0000);
    pulse_clr[1] = 1'b1;
    step();
    chk_all("post_reset_clr", 4'b0000, 4'b1111);
    pulse_clr[1] = 1'b0;
    pulse_set[0] = 1'b1;
    step();
    chk_all("post_reset_set", 4'b1111, 4'b1111);
    idle();
    step();
    chk_all("final_hold", 4'b1111, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
